// File: rtl/bram_addr_pkg.sv
// bram_addr_pkg: shared types for the BRAM address sequencer.
// Mode/state enums and default field widths.
package bram_addr_pkg;

  localparam int DEF_HALF_W  = 5;
  localparam int DEF_COORD_W = 3;

  typedef enum logic [1:0] {
    TILE8 = 2'd0,
    TILE4 = 2'd1,
    SHIFT = 2'd2,
    RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bram_addr_seq_if.sv
// bram_addr_seq_if: address-pair stream, valid/ready.
// master drives addr1/addr2/addr_valid, slave drives addr_ready.
interface bram_addr_seq_if #(
  parameter int HALF_W = 5
);
  logic [2*HALF_W-1:0] addr1;
  logic [2*HALF_W-1:0] addr2;
  logic                addr_valid;
  logic                addr_ready;

  modport master (
    output addr1,
    output addr2,
    output addr_valid,
    input  addr_ready
  );

  modport slave (
    input  addr1,
    input  addr2,
    input  addr_valid,
    output addr_ready
  );
endinterface

// File: rtl/bram_addr_map.sv
// bram_addr_map: combinational (mode, L, tap, x, y) -> addr pair.
// Ports: mode, l, tap (k-1), x, y in; addr1, addr2 out.
module bram_addr_map
  import bram_addr_pkg::*;
#(
  parameter int HALF_W  = DEF_HALF_W,
  parameter int COORD_W = DEF_COORD_W,
  parameter int LW      = 3,
  parameter int KW      = 2
) (
  input  mode_e               mode,
  input  logic [LW-1:0]       l,
  input  logic [KW-1:0]       tap,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  output logic [2*HALF_W-1:0] addr1,
  output logic [2*HALF_W-1:0] addr2
);

  localparam int S = 1 << COORD_W;
  localparam logic [HALF_W-1:0] S_W  = HALF_W'(S);
  localparam logic [HALF_W-1:0] H_W  = HALF_W'(S / 2);
  localparam logic [HALF_W-1:0] S2_W = HALF_W'(2 * S);

  logic [HALF_W-1:0] xe;
  logic [HALF_W-1:0] ye;
  logic [HALF_W-1:0] row;
  logic [HALF_W-1:0] col1;
  logic [HALF_W-1:0] col2;
  logic [HALF_W-1:0] shf;

  // Row and col each wrap in HALF_W bits; no carry
  // crosses from col into row.
  always_comb begin
    xe   = HALF_W'(x);
    ye   = HALF_W'(y);
    row  = '0;
    col1 = '0;
    col2 = '0;
    shf  = (mode == SHIFT) ? HALF_W'(tap) : '0;
    unique case (1'b1)
      (mode == TILE8): begin
        row  = xe + (HALF_W'(l >> 1) << COORD_W);
        col1 = ye + (l[0] ? S2_W : '0);
        col2 = col1 + S_W;
      end
      (mode == TILE4),
      (mode == SHIFT): begin
        row  = xe + (l[2] ? H_W : '0);
        col1 = ye + (HALF_W'(l[1:0]) << COORD_W) + shf;
        col2 = col1 + H_W;
      end
      default: ;
    endcase
  end

  assign addr1 = {row, col1};
  assign addr2 = {row, col2};

endmodule

// File: rtl/bram_addr_seq.sv
// bram_addr_seq: start-triggered L/k/x/y walker streaming addr pairs.
// Ports: clk, rst, start, mode, [abort if BRAM_ADDR_ABORT_EN], bus, busy, done.
module bram_addr_seq
  import bram_addr_pkg::*;
#(
  parameter int HALF_W    = DEF_HALF_W,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int NUM_TILES = 8,
  parameter int K_TAPS    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
`ifdef BRAM_ADDR_ABORT_EN
  input  logic       abort,
`endif
  bram_addr_seq_if.master bus,
  output logic       busy,
  output logic       done
);

  localparam int LW = $clog2(NUM_TILES);
  localparam int KW = (K_TAPS > 1) ? $clog2(K_TAPS) : 1;
  localparam logic [LW-1:0] L_MAX = LW'(NUM_TILES - 1);
  localparam logic [KW-1:0] K_MAX = KW'(K_TAPS - 1);
  localparam logic [COORD_W-1:0] C_MAX = '1;

  state_e state, state_n;
  mode_e  mode_q, mode_in, map_mode;

  logic [LW-1:0]      l_q, l_n;
  logic [KW-1:0]      k_q, k_n;
  logic [COORD_W-1:0] x_q, x_n;
  logic [COORD_W-1:0] y_q, y_n;

  logic [2*HALF_W-1:0] a1_q, a2_q, m1, m2;
  logic                vld_q, vld_n;
  logic                ld, xfer, last, kill;

`ifdef BRAM_ADDR_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign mode_in  = mode_e'(mode);
  assign map_mode = (state == IDLE) ? mode_in : mode_q;
  assign xfer     = vld_q & bus.addr_ready;
  assign last     = (l_q == L_MAX) &&
                    (mode_q != SHIFT || k_q == K_MAX) &&
                    (x_q == C_MAX) && (y_q == C_MAX);

  // The map sees the *next* indices so the pair is registered.
  bram_addr_map #(
    .HALF_W (HALF_W),
    .COORD_W(COORD_W),
    .LW     (LW),
    .KW     (KW)
  ) u_map (
    .mode (map_mode),
    .l    (l_n),
    .tap  (k_n),
    .x    (x_n),
    .y    (y_n),
    .addr1(m1),
    .addr2(m2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    l_n     = l_q;
    k_n     = k_q;
    x_n     = x_q;
    y_n     = y_q;
    vld_n   = vld_q;
    ld      = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        if (start && mode_in != RSVD) begin
          state_n = RUN;
          l_n     = '0;
          k_n     = '0;
          x_n     = '0;
          y_n     = '0;
          vld_n   = 1'b1;
          ld      = 1'b1;
        end
      end
      (state == RUN): begin
        if (kill) begin
          state_n = IDLE;
          vld_n   = 1'b0;
        end else if (xfer && last) begin
          state_n = DONE;
          vld_n   = 1'b0;
        end else if (xfer) begin
          ld  = 1'b1;
          y_n = y_q + 1'b1;
          if (y_q == C_MAX) begin
            x_n = x_q + 1'b1;
            if (x_q == C_MAX) begin
              if (mode_q == SHIFT && k_q != K_MAX) begin
                k_n = k_q + 1'b1;
              end else begin
                k_n = '0;
                l_n = l_q + 1'b1;
              end
            end
          end
        end
      end
      (state == DONE): state_n = IDLE;
      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= TILE8;
      l_q    <= '0;
      k_q    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      a1_q   <= '0;
      a2_q   <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= vld_n;
      if (ld) begin
        l_q  <= l_n;
        k_q  <= k_n;
        x_q  <= x_n;
        y_q  <= y_n;
        a1_q <= m1;
        a2_q <= m2;
      end
      if (state == IDLE && ld) mode_q <= mode_in;
    end
  end

  assign bus.addr1      = a1_q;
  assign bus.addr2      = a2_q;
  assign bus.addr_valid = vld_q;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_bram_addr_seq.sv
// tb_bram_addr_seq: directed bench for bram_addr_seq.
// Optional abort steps compile in with BRAM_ADDR_ABORT_EN.
module tb_bram_addr_seq;
  import bram_addr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       busy;
  logic       done;
`ifdef BRAM_ADDR_ABORT_EN
  logic       abort;
`endif

  bram_addr_seq_if #(.HALF_W(5)) bus ();

  bram_addr_seq dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mode (mode),
`ifdef BRAM_ADDR_ABORT_EN
    .abort(abort),
`endif
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [9:0] a1 [0:2047];
  logic [9:0] a2 [0:2047];

  int beats, dcyc, hbad, dbusy, dvld, adone, abusy;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    step();
    start = 1'b0;
  endtask

  // Drives ready, captures every pair, counts cycles to done.
  task automatic run_job(input int stall_at, input int stall_len,
                         input int start_at);
    int stalled;
    logic [9:0] h1, h2;
    stalled = 0;
    h1 = '0;
    h2 = '0;
    beats = 0; dcyc = -1; hbad = 0;
    dbusy = 0; dvld = 1; adone = 1; abusy = 1;
    for (int c = 0; c < 5000; c++) begin
      start = 1'b0;
      if (done) begin
        dcyc  = c;
        dbusy = int'(busy);
        dvld  = int'(bus.addr_valid);
        break;
      end
      if (c == start_at) begin
        start = 1'b1;
        mode  = 2'd0;
      end
      if (bus.addr_valid) begin
        if (beats == stall_at && stalled < stall_len) begin
          if (stalled == 0) begin
            h1 = bus.addr1;
            h2 = bus.addr2;
          end else if (bus.addr1 !== h1 || bus.addr2 !== h2) begin
            hbad++;
          end
          stalled++;
          bus.addr_ready = 1'b0;
        end else begin
          if (stalled > 0 && beats == stall_at &&
              (bus.addr1 !== h1 || bus.addr2 !== h2))
            hbad++;
          if (beats < 2048) begin
            a1[beats] = bus.addr1;
            a2[beats] = bus.addr2;
          end
          beats++;
          bus.addr_ready = 1'b1;
        end
      end
      step();
    end
    start = 1'b0;
    bus.addr_ready = 1'b1;
    if (dcyc >= 0) begin
      step();
      adone = int'(done);
      abusy = int'(busy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'd0;
    bus.addr_ready = 1'b1;
`ifdef BRAM_ADDR_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    chk("rst_addr1", 32'(bus.addr1), 0);
    chk("rst_addr2", 32'(bus.addr2), 0);
    chk("rst_valid", 32'(bus.addr_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    step();

    // TILE8, ready always high
    launch(2'd0);
    chk("t8_busy0", 32'(busy), 1);
    chk("t8_valid0", 32'(bus.addr_valid), 1);
    chk("t8_a1_b0", 32'(bus.addr1), 0);
    chk("t8_a2_b0", 32'(bus.addr2), 8);
    run_job(-1, 0, -1);
    chk("t8_a1_b64", 32'(a1[64]), 16);
    chk("t8_a2_b64", 32'(a2[64]), 24);
    chk("t8_a1_b511", 32'(a1[511]), 1015);
    chk("t8_a2_b511", 32'(a2[511]), 1023);
    chk("t8_beats", beats, 512);
    chk("t8_done_cyc", dcyc, 512);
    chk("t8_done_busy", dbusy, 1);
    chk("t8_done_valid", dvld, 0);
    chk("t8_done_pulse", adone, 0);
    chk("t8_busy_drop", abusy, 0);

    // Reserved mode start is ignored
    start = 1'b1;
    mode  = 2'd3;
    step();
    start = 1'b0;
    chk("rsvd_busy", 32'(busy), 0);
    chk("rsvd_valid", 32'(bus.addr_valid), 0);
    step();
    chk("rsvd_busy2", 32'(busy), 0);

    // TILE4 with a stray start pulse mid-run
    launch(2'd1);
    chk("t4_a1_b0", 32'(bus.addr1), 0);
    chk("t4_a2_b0", 32'(bus.addr2), 4);
    run_job(-1, 0, 100);
    chk("t4_a1_l4", 32'(a1[256]), 128);
    chk("t4_a2_l4", 32'(a2[256]), 132);
    chk("t4_a1_b511", 32'(a1[511]), 383);
    chk("t4_a2_wrap", 32'(a2[511]), 355);
    chk("t4_beats", beats, 512);
    chk("t4_done_cyc", dcyc, 512);
    chk("t4_idle", abusy, 0);

    // SHIFT
    launch(2'd2);
    run_job(-1, 0, -1);
    chk("sh_a1_k1", 32'(a1[0]), 0);
    chk("sh_a2_k1", 32'(a2[0]), 4);
    chk("sh_a1_k3", 32'(a1[128]), 2);
    chk("sh_a2_k3", 32'(a2[128]), 6);
    chk("sh_a1_last", 32'(a1[1535]), 353);
    chk("sh_a2_last", 32'(a2[1535]), 357);
    chk("sh_beats", beats, 1536);
    chk("sh_done_cyc", dcyc, 1536);

    // Backpressure: 5 stall cycles at beat 100
    launch(2'd0);
    run_job(100, 5, -1);
    chk("bp_hold", hbad, 0);
    chk("bp_a1_b100", 32'(a1[100]), 148);
    chk("bp_a2_b100", 32'(a2[100]), 156);
    chk("bp_a1_b101", 32'(a1[101]), 149);
    chk("bp_beats", beats, 512);
    chk("bp_done_cyc", dcyc, 517);

    // Asynchronous reset mid-job
    launch(2'd0);
    for (int i = 0; i < 200; i++) step();
    #2 rst = 1'b1;
    #1;
    chk("mr_addr1", 32'(bus.addr1), 0);
    chk("mr_addr2", 32'(bus.addr2), 0);
    chk("mr_valid", 32'(bus.addr_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    #1 rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (done || busy) seen++;
      end
      chk("mr_quiet", seen, 0);
    end

`ifdef BRAM_ADDR_ABORT_EN
    launch(2'd0);
    for (int i = 0; i < 10; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_valid", 32'(bus.addr_valid), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    step();
    chk("ab_done2", 32'(done), 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
